wca_ddc_retune_ctrl: RTL and testbench

Sequencer that safely reconfigures the DDC chain (phase generator, CIC decimator, halfband) at run time. It accepts one retune request (IF frequency word, decimation rate, bypass flags) and quiesces the DDC. It then writes the frequency and rate registers as byte writes on the register bus, pulses the DDC state clear and discards settling samples. Finally it re-enables the DDC and un-gates its output strobe. It sits between the host command logic and the DDC instance.

---
 rtl/wca_ddc_retune_ctrl_pkg.sv | 23 ++
 rtl/wca_ddc_retune_ctrl_if.sv | 22 ++
 rtl/wca_rbus_byte_writer.sv | 44 ++++
 rtl/wca_ddc_retune_ctrl.sv | 155 +++++++++++++++
 tb/tb_wca_ddc_retune_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wca_ddc_retune_ctrl_pkg.sv
// Shared definitions for the DDC retune controller: sequencer state
// encoding and default register addresses / timing constants.
package wca_ddc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    WRF,
    WRR,
    CLR,
    SETTLE,
    RUN
  } state_t;

  localparam int IF_FREQ_ADDR_DEF    = 0;
  localparam int DECIM_RATE_ADDR_DEF = 1;
  localparam int MIN_RATE_DEF        = 2;
  localparam int QUIESCE_CYC_DEF     = 16;
  localparam int ACLR_CYC_DEF        = 4;
  localparam int SETTLE_SAMPLES_DEF  = 32;
  localparam int TIMEOUT_CYC_DEF     = 65535;

endpackage

// File: rtl/wca_ddc_retune_ctrl_if.sv
// Bus bundles used by the retune controller.
//   wca_req_if  : host retune request (valid/ready, freq, rate, bypass flags)
//   wca_rbus_if : byte-wide register write bus toward the DDC
interface wca_req_if;
  logic        valid;
  logic        ready;
  logic [31:0] freq;
  logic [12:0] rate;
  logic [3:0]  flags;

  modport master (output valid, freq, rate, flags, input ready);
  modport slave  (input valid, freq, rate, flags, output ready);
endinterface

interface wca_rbus_if;
  logic [7:0] addr;
  logic [7:0] data;
  logic       strobe;

  modport master (output addr, data, strobe);
  modport slave  (input addr, data, strobe);
endinterface

// File: rtl/wca_rbus_byte_writer.sv
// Serialises an N-byte word (LS byte first) into addressed byte strobes.
// While en is high a strobe is issued every other cycle (strobe, idle, ...);
// done pulses on the idle cycle after the last byte.
// Ports: clock, reset (async active-low), en, nbytes (1..4), addr, word,
//        wr_addr/wr_data/wr_strobe (register bus), done.
module wca_rbus_byte_writer (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  nbytes,
  input  logic [7:0]  addr,
  input  logic [31:0] word,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_strobe,
  output logic        done
);

  logic [1:0] idx;
  logic       phase;
  logic       last;

  assign last      = ({1'b0, idx} == (nbytes - 3'd1));
  assign done      = en & phase & last;
  assign wr_strobe = en & ~phase;
  // Address/data stay on the current byte across its strobe and idle cycle.
  assign wr_addr   = en ? addr : '0;
  assign wr_data   = en ? word[{idx, 3'b000} +: 8] : '0;

  // Restart on done so back-to-back words (WRF then WRR) begin at byte 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      phase <= 1'b0;
    end else if (!en || done) begin
      idx   <= '0;
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
      if (phase) idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/wca_ddc_retune_ctrl.sv
// Run-time DDC retune sequencer. Accepts a retune request, disables the DDC,
// writes the IF frequency word and decimation rate as byte writes, pulses the
// DDC state clear, discards settling samples and then re-enables the output.
// Ports: clock, reset (async active-low), req (request handshake, slave),
//        rbus (register byte bus, master), ddc_enable, ddc_aclr, ddc_cfgflags,
//        ddc_strobe (raw DDC strobe), out_strobe (gated), busy, err_rate,
//        err_timeout (sticky until reset).
//
// state   | meaning
// IDLE    | after reset, DDC disabled, waiting for first request
// QUIESCE | DDC held disabled before register writes
// WRF     | four byte writes of the IF frequency word
// WRR     | two byte writes of the decimation rate
// CLR     | DDC state clear asserted, bypass flags applied
// SETTLE  | DDC enabled, output strobes discarded
// RUN     | DDC enabled, output strobes forwarded
module wca_ddc_retune_ctrl
  import wca_ddc_pkg::*;
#(
  parameter int IF_FREQ_ADDR    = IF_FREQ_ADDR_DEF,
  parameter int DECIM_RATE_ADDR = DECIM_RATE_ADDR_DEF,
  parameter int QUIESCE_CYC     = QUIESCE_CYC_DEF,
  parameter int ACLR_CYC        = ACLR_CYC_DEF,
  parameter int SETTLE_SAMPLES  = SETTLE_SAMPLES_DEF,
  parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
  parameter int MIN_RATE        = MIN_RATE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  wca_req_if.slave         req,
  wca_rbus_if.master       rbus,
  output logic             ddc_enable,
  output logic             ddc_aclr,
  output logic [3:0]       ddc_cfgflags,
  input  logic             ddc_strobe,
  output logic             out_strobe,
  output logic             busy,
  output logic             err_rate,
  output logic             err_timeout
);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [5:0]  samp, samp_d;
  logic        to_set;
  logic [31:0] freq_q;
  logic [12:0] rate_q;
  logic [3:0]  flags_q;
  logic        accept, rate_ok;
  logic        wr_en, wr_done;
  logic        in_wrr;

  assign accept  = req.valid && (state == IDLE || state == RUN);
  assign rate_ok = (req.rate >= 13'(MIN_RATE));
  assign in_wrr  = (state == WRR);
  assign wr_en   = (state == WRF) || in_wrr;

  wca_rbus_byte_writer u_writer (
    .clock     (clock),
    .reset     (reset),
    .en        (wr_en),
    .nbytes    (in_wrr ? 3'd2 : 3'd4),
    .addr      (in_wrr ? 8'(DECIM_RATE_ADDR) : 8'(IF_FREQ_ADDR)),
    .word      (in_wrr ? {19'b0, rate_q} : freq_q),
    .wr_addr   (rbus.addr),
    .wr_data   (rbus.data),
    .wr_strobe (rbus.strobe),
    .done      (wr_done)
  );

  // One down-counter serves the quiesce, clear and settle-timeout intervals;
  // each is loaded with length-1 on entry and the state exits at zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    samp_d  = samp;
    to_set  = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (accept && rate_ok) begin
          state_d = QUIESCE;
          cnt_d   = 16'(QUIESCE_CYC - 1);
        end
      end
      QUIESCE: begin
        if (cnt == '0) state_d = WRF;
        else           cnt_d   = cnt - 16'd1;
      end
      WRF: begin
        if (wr_done) state_d = WRR;
      end
      WRR: begin
        if (wr_done) begin
          state_d = CLR;
          cnt_d   = 16'(ACLR_CYC - 1);
        end
      end
      CLR: begin
        if (cnt == '0) begin
          state_d = SETTLE;
          cnt_d   = 16'(TIMEOUT_CYC - 1);
          samp_d  = '0;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      SETTLE: begin
        if (ddc_strobe) samp_d = samp + 6'd1;
        // Sample completion wins over a simultaneous timeout.
        if (ddc_strobe && samp == 6'(SETTLE_SAMPLES - 1)) begin
          state_d = RUN;
        end else if (cnt == '0) begin
          state_d = RUN;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      samp         <= '0;
      freq_q       <= '0;
      rate_q       <= '0;
      flags_q      <= '0;
      ddc_cfgflags <= '0;
      err_rate     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      samp  <= samp_d;
      if (accept && rate_ok) begin
        freq_q  <= req.freq;
        rate_q  <= req.rate;
        flags_q <= req.flags;
      end
      if (accept && !rate_ok) err_rate <= 1'b1;
      if (to_set)             err_timeout <= 1'b1;
      if (in_wrr && wr_done)  ddc_cfgflags <= flags_q;
    end
  end

  assign req.ready  = accept;
  assign ddc_enable = (state == RUN) || (state == SETTLE);
  assign ddc_aclr   = (state == CLR);
  assign out_strobe = (state == RUN) && ddc_strobe;
  assign busy       = (state != IDLE) && (state != RUN);

endmodule

// File: tb/tb_wca_ddc_retune_ctrl.sv
// Scoreboard bench for wca_ddc_retune_ctrl: the driver pushes expected byte
// writes per accepted request; monitors compare register writes and a
// timeline model of the retune sequence against the DUT every cycle.
module tb_wca_ddc_retune_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  wca_req_if  rif ();
  wca_rbus_if rbus ();

  logic       ddc_enable, ddc_aclr, ddc_strobe, out_strobe, busy;
  logic       err_rate, err_timeout;
  logic [3:0] ddc_cfgflags;

  wca_ddc_retune_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req          (rif),
    .rbus         (rbus),
    .ddc_enable   (ddc_enable),
    .ddc_aclr     (ddc_aclr),
    .ddc_cfgflags (ddc_cfgflags),
    .ddc_strobe   (ddc_strobe),
    .out_strobe   (out_strobe),
    .busy         (busy),
    .err_rate     (err_rate),
    .err_timeout  (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sequence lengths in clocks: quiesce 16, freq writes 8, rate writes 4,
  // clear 4; settling starts 33 clocks after the acceptance cycle.
  localparam int T_CLR    = 1 + 16 + 8 + 4;
  localparam int T_SETTLE = T_CLR + 4;
  localparam int N_DISC   = 32;
  localparam int N_TMO    = 65535;

  logic [15:0] wq[$];
  int          wr_seen = 0;
  int          cyc = 0;
  int          strobe_mode = 1;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    ddc_strobe = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      ddc_strobe = (strobe_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  // Register-write scoreboard.
  always @(negedge clock) begin
    if (reset && rbus.strobe) begin
      wr_seen++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", {rbus.addr, rbus.data});
      end else begin
        chk("wr_byte", {rbus.addr, rbus.data}, wq.pop_front());
      end
    end
  end

  // Timeline model of the retune sequence.
  bit         busy_m, run_m, err_rate_m, err_to_m;
  int         acc_c, disc, off;
  logic [3:0] flags_m, cfg_m;
  logic       e_en, e_aclr, e_busy, e_out, e_rdy;
  logic [3:0] e_cfg;

  always @(negedge clock) begin
    if (!reset) begin
      busy_m = 0; run_m = 0; err_rate_m = 0; err_to_m = 0;
      cfg_m = 4'h0; flags_m = 4'h0; disc = 0; acc_c = 0;
    end else begin
      off = cyc - acc_c;
      if (busy_m) begin
        e_en   = (off >= T_SETTLE);
        e_aclr = (off >= T_CLR) && (off < T_SETTLE);
        e_busy = 1'b1;
        e_out  = 1'b0;
        e_rdy  = 1'b0;
        e_cfg  = (off >= T_CLR) ? flags_m : cfg_m;
      end else begin
        e_en   = run_m;
        e_aclr = 1'b0;
        e_busy = 1'b0;
        e_out  = run_m && ddc_strobe;
        e_rdy  = rif.valid;
        e_cfg  = cfg_m;
      end
      chk("ddc_enable", ddc_enable, e_en);
      chk("ddc_aclr", ddc_aclr, e_aclr);
      chk("busy", busy, e_busy);
      chk("out_strobe", out_strobe, e_out);
      chk("req_ready", rif.ready, e_rdy);
      chk("ddc_cfgflags", ddc_cfgflags, e_cfg);
      chk("err_rate", err_rate, err_rate_m);
      chk("err_timeout", err_timeout, err_to_m);
      if (busy_m) begin
        if (off == T_CLR) cfg_m = flags_m;
        if (off >= T_SETTLE) begin
          if (ddc_strobe) disc++;
          if (ddc_strobe && disc == N_DISC) begin
            busy_m = 0; run_m = 1;
          end else if (off == T_SETTLE + N_TMO - 1) begin
            busy_m = 0; run_m = 1; err_to_m = 1;
          end
        end
      end else if (rif.valid) begin
        if (rif.rate >= 13'd2) begin
          busy_m = 1; run_m = 0; acc_c = cyc; disc = 0; flags_m = rif.flags;
        end else begin
          err_rate_m = 1;
        end
      end
    end
  end

  task automatic issue_req(input logic [31:0] f, input logic [12:0] r, input logic [3:0] fl,
                           input int budget);
    int n;
    @(posedge clock);
    #1;
    rif.valid = 1'b1; rif.freq = f; rif.rate = r; rif.flags = fl;
    n = 0;
    forever begin
      @(negedge clock);
      if (rif.ready) break;
      n++;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no_ready required=ready");
        break;
      end
    end
    if (rif.ready && r >= 13'd2) begin
      wq.push_back({8'd0, f[7:0]});
      wq.push_back({8'd0, f[15:8]});
      wq.push_back({8'd0, f[23:16]});
      wq.push_back({8'd0, f[31:24]});
      wq.push_back({8'd1, r[7:0]});
      wq.push_back({8'd1, 3'b000, r[12:8]});
    end
    @(posedge clock);
    #1;
    rif.valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outs"}, {rif.ready, rbus.strobe, ddc_enable, ddc_aclr, out_strobe, busy,
                         err_rate, err_timeout}, 8'h00);
    chk({tag, "_bus"}, {rbus.addr, rbus.data}, 16'h0000);
    chk({tag, "_cfg"}, ddc_cfgflags, 4'h0);
  endtask

  initial begin
    int n;
    rif.valid = 1'b0; rif.freq = '0; rif.rate = '0; rif.flags = '0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b1;

    issue_req(32'h12345678, 13'd100, 4'h0, 10);
    wait_idle(2000);
    chk("seq1_writes_done", wq.size(), 0);
    chk("seq1_run_enable", ddc_enable, 1'b1);

    issue_req(32'hdeadbeef, 13'd1, 4'h5, 10);
    repeat (4) @(posedge clock);
    #1;
    chk("rate1_err", err_rate, 1'b1);
    chk("rate1_enable_kept", ddc_enable, 1'b1);

    for (int i = 0; i < 4; i++) begin
      issue_req($urandom, 13'($urandom_range(2, 8191)), 4'($urandom_range(0, 14)), 10);
      wait_idle(2000);
    end

    issue_req($urandom, 13'd5, 4'h3, 10);
    issue_req(32'hcafef00d, 13'd8191, 4'hF, 5000);
    wait_idle(2000);
    #1;
    chk("flagsF_cfg", ddc_cfgflags, 4'hF);

    n = wr_seen;
    issue_req(32'h12345678, 13'd300, 4'h6, 10);
    for (int k = 0; k < 200 && wr_seen < n + 2; k++) @(negedge clock);
    chk("midwrf_two_bytes", wr_seen - n, 2);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_zero("midwrf");
    wq.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    issue_req(32'ha1b2c3d4, 13'd2, 4'h9, 10);
    wait_idle(2000);
    chk("restart_writes_done", wq.size(), 0);

    strobe_mode = 0;
    issue_req($urandom, 13'd77, 4'h1, 10);
    wait_idle(70000);
    #1;
    chk("timeout_err", err_timeout, 1'b1);
    chk("timeout_run", {ddc_enable, busy}, 2'b10);
    strobe_mode = 1;
    repeat (20) @(posedge clock);

    chk("final_queue_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
